// File: rtl/alu_script_driver_pkg.sv
// Shared encodings for the ALU script driver: FSM states, switch-bus
// phases and the saturating counter helper.
package alu_script_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_PRESENT  = 3'd2,
    ST_STROBE   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_WAIT_RES = 3'd5,
    ST_CHECK    = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  // Which field of the current entry is on the switch bus.
  localparam logic [1:0] PH_OP = 2'd0;
  localparam logic [1:0] PH_A  = 2'd1;
  localparam logic [1:0] PH_B  = 2'd2;

  // Pass/fail counters stop here instead of wrapping.
  localparam logic [7:0] CNT_SAT = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/alu_script_driver_script_delay_counter.sv
// Loadable down-counter with a zero flag. Loading N-1 makes the flag rise
// after N cycles; once at zero the count stays there.
module script_delay_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_script_driver.sv
// Script-driven operator for the ALU keypress/switch load protocol: for each
// ROM entry it presents opcode, A and B with one enter strobe each, then
// compares the ALU result register against the expected value.
module alu_script_driver
  import alu_script_driver_pkg::*;
#(
  parameter int ENTRY_COUNT = 8,
  parameter int ADDR_W      = 3,
  parameter int GAP_CYCLES  = 4,
  parameter int RESULT_WAIT = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] entry_addr,
  input  logic [3:0]        entry_opcode,
  input  logic [7:0]        entry_a,
  input  logic [7:0]        entry_b,
  input  logic [15:0]       entry_expected,
  input  logic [15:0]       result_in,
  output logic [7:0]        sw_data,
  output logic              enter,
  output logic              busy,
  output logic              done,
  output logic [7:0]        pass_count,
  output logic [7:0]        fail_count,
  output logic [ADDR_W-1:0] first_fail
);

  localparam int DLY_MAX = (GAP_CYCLES > RESULT_WAIT) ? GAP_CYCLES : RESULT_WAIT;
  localparam int DLY_W   = $clog2(DLY_MAX) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRY_COUNT - 1);
  localparam logic [DLY_W-1:0]  GAP_LOAD  = DLY_W'(GAP_CYCLES - 1);
  localparam logic [DLY_W-1:0]  WAIT_LOAD = DLY_W'(RESULT_WAIT - 1);

  state_e             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         op_q, op_d;
  logic [7:0]         a_q, a_d;
  logic [7:0]         b_q, b_d;
  logic [15:0]        exp_q, exp_d;
  logic [7:0]         pass_q, pass_d;
  logic [7:0]         fail_q, fail_d;
  logic [ADDR_W-1:0]  first_q, first_d;
  logic               done_q, done_d;

  logic               dly_load;
  logic [DLY_W-1:0]   dly_val;
  logic               dly_zero;

  script_delay_counter #(.W(DLY_W)) u_delay (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .zero_o     (dly_zero)
  );

  // Next-state, entry latching, scoring and delay-counter loads.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    addr_d   = addr_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    exp_d    = exp_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    first_d  = first_q;
    done_d   = done_q;
    dly_load = 1'b0;
    dly_val  = '0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pass_d  = 8'd0;
          fail_d  = 8'd0;
          first_d = '0;
          done_d  = 1'b0;
          addr_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        op_d     = entry_opcode;
        a_d      = entry_a;
        b_d      = entry_b;
        exp_d    = entry_expected;
        phase_d  = PH_OP;
        dly_load = 1'b1;
        dly_val  = GAP_LOAD;
        state_d  = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (dly_zero) state_d = ST_STROBE;
      end
      ST_STROBE: begin
        dly_load = 1'b1;
        dly_val  = GAP_LOAD;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        if (dly_zero) begin
          dly_load = 1'b1;
          if (phase_q == PH_B) begin
            dly_val = WAIT_LOAD;
            state_d = ST_WAIT_RES;
          end else begin
            dly_val = GAP_LOAD;
            phase_d = phase_q + 2'd1;
            state_d = ST_PRESENT;
          end
        end
      end
      ST_WAIT_RES: begin
        if (dly_zero) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (result_in == exp_q) begin
          pass_d = sat_inc(pass_q);
        end else begin
          fail_d = sat_inc(fail_q);
          if (fail_q == 8'd0) first_d = addr_q;
        end
        if (addr_q == LAST_ADDR) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= PH_OP;
      addr_q  <= '0;
      op_q    <= 4'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      exp_q   <= 16'd0;
      pass_q  <= 8'd0;
      fail_q  <= 8'd0;
      first_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end

  // Switch bus carries the current phase's field only while presenting.
  always_comb begin
    sw_data = 8'h00;
    if (state_q == ST_PRESENT || state_q == ST_STROBE || state_q == ST_HOLD) begin
      case (phase_q)
        PH_OP:   sw_data = {4'b0000, op_q};
        PH_A:    sw_data = a_q;
        PH_B:    sw_data = b_q;
        default: sw_data = 8'h00;
      endcase
    end
  end

  assign enter      = (state_q == ST_STROBE);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = done_q;
  assign entry_addr = addr_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign first_fail = first_q;

endmodule

// File: tb/tb_alu_script_driver.sv
// Directed bench for alu_script_driver: an 8-entry instance with a small
// ROM table and a single-entry instance, checked against hand-computed values.
module tb_alu_script_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- 8-entry instance ----------------
  logic [3:0]  rom_op  [8];
  logic [7:0]  rom_a   [8];
  logic [7:0]  rom_b   [8];
  logic [15:0] rom_exp [8];
  logic [7:0]  bad_mask = 8'h00;

  logic        start8 = 1'b0;
  logic [2:0]  addr8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, sw8, pass8, fail8;
  logic [15:0] exp8, res8;
  logic        enter8, busy8, done8;
  logic [2:0]  first8;

  initial begin
    // op, A, B, expected (add/add/sub/mul/and/or/xor/mul)
    rom_op[0] = 4'h2; rom_a[0] = 8'h05; rom_b[0] = 8'h03; rom_exp[0] = 16'h0008;
    rom_op[1] = 4'h2; rom_a[1] = 8'hFF; rom_b[1] = 8'h01; rom_exp[1] = 16'h0100;
    rom_op[2] = 4'h3; rom_a[2] = 8'h10; rom_b[2] = 8'h04; rom_exp[2] = 16'h000C;
    rom_op[3] = 4'h4; rom_a[3] = 8'h0C; rom_b[3] = 8'h0A; rom_exp[3] = 16'h0078;
    rom_op[4] = 4'h5; rom_a[4] = 8'hF0; rom_b[4] = 8'h3C; rom_exp[4] = 16'h0030;
    rom_op[5] = 4'h6; rom_a[5] = 8'h0F; rom_b[5] = 8'h30; rom_exp[5] = 16'h003F;
    rom_op[6] = 4'h7; rom_a[6] = 8'hAA; rom_b[6] = 8'hFF; rom_exp[6] = 16'h0055;
    rom_op[7] = 4'h8; rom_a[7] = 8'hFF; rom_b[7] = 8'hFF; rom_exp[7] = 16'hFE01;
  end

  assign op8  = rom_op[addr8];
  assign a8   = rom_a[addr8];
  assign b8   = rom_b[addr8];
  assign exp8 = rom_exp[addr8];
  assign res8 = rom_exp[addr8] ^ {15'd0, bad_mask[addr8]};

  alu_script_driver #(
    .ENTRY_COUNT(8), .ADDR_W(3), .GAP_CYCLES(4), .RESULT_WAIT(3)
  ) dut8 (
    .CLOCK_50       (clk),
    .reset          (rst),
    .start          (start8),
    .entry_addr     (addr8),
    .entry_opcode   (op8),
    .entry_a        (a8),
    .entry_b        (b8),
    .entry_expected (exp8),
    .result_in      (res8),
    .sw_data        (sw8),
    .enter          (enter8),
    .busy           (busy8),
    .done           (done8),
    .pass_count     (pass8),
    .fail_count     (fail8),
    .first_fail     (first8)
  );

  // ---------------- single-entry instance ----------------
  logic        start1 = 1'b0;
  logic [0:0]  addr1;
  logic [7:0]  sw1, pass1, fail1;
  logic        enter1, busy1, done1;
  logic [0:0]  first1;
  logic [15:0] res1 = 16'h0008;

  alu_script_driver #(
    .ENTRY_COUNT(1), .ADDR_W(1), .GAP_CYCLES(4), .RESULT_WAIT(3)
  ) dut1 (
    .CLOCK_50       (clk),
    .reset          (rst),
    .start          (start1),
    .entry_addr     (addr1),
    .entry_opcode   (4'h2),
    .entry_a        (8'h05),
    .entry_b        (8'h03),
    .entry_expected (16'h0008),
    .result_in      (res1),
    .sw_data        (sw1),
    .enter          (enter1),
    .busy           (busy1),
    .done           (done1),
    .pass_count     (pass1),
    .fail_count     (fail1),
    .first_fail     (first1)
  );

  // ---------------- enter-pulse recorder ----------------
  int         p8_n = 0;
  int         p8_cyc  [128];
  logic [7:0] p8_sw   [128];
  logic [2:0] p8_addr [128];
  int         p1_n = 0;
  int         p1_cyc  [8];
  logic [7:0] p1_sw   [8];

  initial forever begin
    @(negedge clk);
    if (enter8 === 1'b1) begin
      if (p8_n < 128) begin
        p8_cyc[p8_n]  = cyc;
        p8_sw[p8_n]   = sw8;
        p8_addr[p8_n] = addr8;
      end
      p8_n++;
    end
    if (enter1 === 1'b1) begin
      if (p1_n < 8) begin
        p1_cyc[p1_n] = cyc;
        p1_sw[p1_n]  = sw1;
      end
      p1_n++;
    end
  end

  // ---------------- helpers ----------------
  task automatic kick8(output int ts);
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; ts = cyc;
  endtask

  task automatic wait_done8(input int ts, output int el);
    int n = 0;
    while (done8 !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done8_reached", {31'd0, done8}, 32'd1);
    el = cyc - ts;
  endtask

  function automatic logic [7:0] exp_sw(input int k);
    int e = k / 3;
    int ph = k % 3;
    if (ph == 0) return {4'h0, rom_op[e]};
    if (ph == 1) return rom_a[e];
    return rom_b[e];
  endfunction

  // Verify 24 recorded pulses starting at base: data, address and spacing.
  task automatic check_pulses8(input int base, input string tag);
    chk({tag, "_pulse_cnt"}, p8_n - base, 24);
    for (int k = 0; k < 24; k++) begin
      if (base + k < 128 && base + k < p8_n) begin
        chk({tag, "_sw"}, {24'd0, p8_sw[base + k]}, {24'd0, exp_sw(k)});
        chk({tag, "_addr"}, {29'd0, p8_addr[base + k]}, k / 3);
        if (k % 3 != 0)
          chk({tag, "_gap"}, p8_cyc[base + k] - p8_cyc[base + k - 1], 9);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ts, el, base;

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sw", {24'd0, sw8}, 0);
    chk("rst_enter", {31'd0, enter8}, 0);
    chk("rst_busy", {31'd0, busy8}, 0);
    chk("rst_done", {31'd0, done8}, 0);
    chk("rst_pass", {24'd0, pass8}, 0);
    chk("rst_fail", {24'd0, fail8}, 0);
    chk("rst_first", {29'd0, first8}, 0);
    chk("rst_addr", {29'd0, addr8}, 0);

    // Reset during the third PRESENT cycle of entry 0
    base = p8_n;
    kick8(ts);
    chk("run_busy", {31'd0, busy8}, 1);
    repeat (3) @(negedge clk);
    chk("present_sw_op", {24'd0, sw8}, 32'h02);
    rst = 1'b1;
    #1;
    chk("abort_sw", {24'd0, sw8}, 0);
    chk("abort_enter", {31'd0, enter8}, 0);
    chk("abort_busy", {31'd0, busy8}, 0);
    chk("abort_pass", {24'd0, pass8}, 0);
    chk("abort_fail", {24'd0, fail8}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_no_enter", p8_n - base, 0);
    chk("abort_idle_busy", {31'd0, busy8}, 0);

    // Single-entry script
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; ts = cyc;
    begin
      int n = 0;
      while (done1 !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("one_done", {31'd0, done1}, 1);
    chk("one_latency", cyc - ts, 32);
    chk("one_pulses", p1_n, 3);
    chk("one_sw0", {24'd0, p1_sw[0]}, 32'h02);
    chk("one_sw1", {24'd0, p1_sw[1]}, 32'h05);
    chk("one_sw2", {24'd0, p1_sw[2]}, 32'h03);
    chk("one_first_at", p1_cyc[0] - ts, 5);
    chk("one_gap01", p1_cyc[1] - p1_cyc[0], 9);
    chk("one_gap12", p1_cyc[2] - p1_cyc[1], 9);
    chk("one_pass", {24'd0, pass1}, 1);
    chk("one_fail", {24'd0, fail1}, 0);
    chk("one_busy", {31'd0, busy1}, 0);

    // Full run, entries 3 and 6 wrong
    bad_mask = 8'b0100_1000;
    base = p8_n;
    kick8(ts);
    wait_done8(ts, el);
    chk("full_len", el, 256);
    chk("full_pass", {24'd0, pass8}, 6);
    chk("full_fail", {24'd0, fail8}, 2);
    chk("full_first", {29'd0, first8}, 3);
    chk("full_busy", {31'd0, busy8}, 0);
    check_pulses8(base, "full");

    // start pulsed while busy in entry 2 is ignored
    base = p8_n;
    kick8(ts);
    repeat (70) @(negedge clk);
    chk("busy_addr", {29'd0, addr8}, 2);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(ts, el);
    chk("busy_len", el, 256);
    chk("busy_pass", {24'd0, pass8}, 6);
    check_pulses8(base, "busy");

    // Re-start from DONE clears the results
    repeat (5) @(negedge clk);
    chk("done_sticky", {31'd0, done8}, 1);
    base = p8_n;
    kick8(ts);
    chk("rerun_done_clr", {31'd0, done8}, 0);
    chk("rerun_pass_clr", {24'd0, pass8}, 0);
    chk("rerun_fail_clr", {24'd0, fail8}, 0);
    chk("rerun_first_clr", {29'd0, first8}, 0);
    chk("rerun_busy", {31'd0, busy8}, 1);
    wait_done8(ts, el);
    chk("rerun_len", el, 256);
    chk("rerun_pass", {24'd0, pass8}, 6);
    chk("rerun_fail", {24'd0, fail8}, 2);
    chk("rerun_first", {29'd0, first8}, 3);
    chk("rerun_pulses", p8_n - base, 24);

    // fail_count saturation from a preset of 254
    bad_mask = 8'hFF;
    kick8(ts);
    force dut8.fail_q = 8'd254;
    @(negedge clk);
    release dut8.fail_q;
    @(negedge clk);
    chk("sat_preset", {24'd0, fail8}, 254);
    wait_done8(ts, el);
    chk("sat_fail", {24'd0, fail8}, 255);
    chk("sat_pass", {24'd0, pass8}, 0);
    chk("sat_first", {29'd0, first8}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_script_driver.md
Name: alu_script_driver

Overview:
- Automatic initiator for the ALU datapath's keypress/switch load protocol; replaces the human operator at the switches and enter key.
- Walks a script of (opcode, A, B, expected) entries from an external ROM.
- For each entry: presents the opcode, then A, then B on the switch bus, each with one enter strobe. Then samples the registered result and compares it to the expected value.
- Sits beside the ALU controller in self-test builds; its enter and switch outputs are muxed onto the controller's enter and switch inputs.

Parameters:
- ENTRY_COUNT, 8: number of script entries (≥1).
- ADDR_W, 3: entry address width; must satisfy 2^ADDR_W ≥ ENTRY_COUNT.
- GAP_CYCLES, 4: cycles the switch data is stable before the enter strobe, and again after it (≥1).
- RESULT_WAIT, 3: cycles waited after the B phase before sampling the result (≥1).

Ports:
- CLOCK_50 in 1: system clock; all state changes on the rising edge.
- reset in 1: asynchronous, active-high reset.
- start in 1: one-cycle run request; ignored while busy=1.
- entry_addr out ADDR_W: script ROM address (registered).
- entry_opcode in 4: ROM opcode; combinational, valid in the same cycle as entry_addr.
- entry_a in 8: ROM operand A.
- entry_b in 8: ROM operand B.
- entry_expected in 16: ROM expected result.
- result_in in 16: registered ALU result register output.
- sw_data out 8: switch-bus replacement.
- enter out 1: one-cycle enter strobe.
- busy out 1: high from the cycle after an accepted start until DONE is reached.
- done out 1: sticky; set on entry to DONE, cleared by the next accepted start.
- pass_count out 8: entries whose result matched.
- fail_count out 8: entries whose result mismatched.
- first_fail out ADDR_W: address of the first mismatching entry; holds 0 if none.

Behaviour:
- Reset values: all outputs 0, state IDLE, phase 0, counters 0. Reset mid-run aborts immediately; no further enter pulses are issued.
- FSM states: IDLE, FETCH, PRESENT, STROBE, HOLD, WAIT_RES, CHECK, DONE.
- IDLE/DONE:
  - start=1 clears pass_count, fail_count, first_fail, done and entry_addr, then goes to FETCH.
  - From DONE, start re-runs the script.
- FETCH (1 cycle):
  - Latches entry_opcode, entry_a, entry_b and entry_expected into internal registers.
  - Sets phase=0, then goes to PRESENT.
- sw_data value by phase:
  - phase 0: {4'b0000, opcode}.
  - phase 1: A.
  - phase 2: B.
  - sw_data drives this value in PRESENT, STROBE and HOLD; it is 0 in every other state.
- PRESENT: GAP_CYCLES cycles, then STROBE.
- STROBE: exactly 1 cycle with enter=1, then HOLD. enter is 0 in every other state.
- HOLD: GAP_CYCLES cycles.
  - If phase<2: phase increments and the FSM returns to PRESENT.
  - If phase=2: go to WAIT_RES.
- WAIT_RES: RESULT_WAIT cycles, then CHECK.
- CHECK (1 cycle): compares result_in against the latched expected value.
  - Match: pass_count increments.
  - Mismatch: fail_count increments. If fail_count was 0, first_fail takes entry_addr.
  - Counters saturate at 255 and never wrap.
  - Then:
    - If entry_addr = ENTRY_COUNT-1: go to DONE and set done.
    - Otherwise: entry_addr increments and the FSM goes to FETCH.
- Cycles per entry: 1 + 3·(2·GAP_CYCLES+1) + RESULT_WAIT + 1. With the defaults this is 32 cycles per entry and 256 cycles for the full script.
- Enter spacing: consecutive enter pulses are 2·GAP_CYCLES+1 cycles apart. This satisfies the keypress controller's one-load-per-press rule.
- ROM timing: entry_addr only changes in CHECK/IDLE, so ROM data is stable for the whole FETCH cycle.
- start arriving in the same cycle as a CHECK→DONE transition is ignored; it is not queued.

Decomposition:
- Shared package/header constants:
  - State encodings (3-bit localparams).
  - Phase codes PH_OP=0, PH_A=1, PH_B=2.
  - Counter saturation value 8'hFF.
- One sub-module, script_delay_counter: a loadable down-counter with a zero flag, used by PRESENT, HOLD and WAIT_RES. All other logic stays in the FSM module.

Test Plan:
- Reset during the third PRESENT cycle of entry 0 → sw_data=0, enter=0, busy=0, all counters 0. No enter pulse appears afterward until start.
- Single-entry script, ENTRY_COUNT=1, entry = op 4'h2, A=8'h05, B=8'h03, expected 16'h0008, result_in driven to 16'h0008:
  - Exactly 3 enter pulses, carrying sw_data=8'h02, 8'h05, 8'h03 respectively.
  - Pulses are 9 cycles apart.
  - pass_count=1, done=1 at cycle 32 after start.
- Full 8-entry run with result_in wrong on entries 3 and 6 → pass_count=6, fail_count=2, first_fail=3, done=1 after 256 cycles.
- start pulsed while busy (mid entry 2) → ignored: entry_addr sequence unchanged, only 24 enter pulses total.
- Re-start from DONE → counters and first_fail cleared, done drops, a second identical 256-cycle run follows.
- fail_count saturation: ENTRY_COUNT=8 with internal counters preset to 254 by forced stimulus, then all entries fail → fail_count sticks at 255.
